// File: rtl/seq_controller_pkg.sv
// Shared FSM type, bus addresses and tempo limits for the pattern sequencer.
package seq_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_PERIOD,
    S_WR_ENABLE,
    S_WAIT
  } state_t;

  localparam logic [2:0] ADDR_PERIOD_A = 3'b000;
  localparam logic [2:0] ADDR_PERIOD_B = 3'b001;
  localparam logic [2:0] ADDR_VOL_A    = 3'b010;
  localparam logic [2:0] ADDR_VOL_B    = 3'b011;
  localparam logic [2:0] ADDR_VOL_N    = 3'b100;
  localparam logic [2:0] ADDR_ENABLE   = 3'b101;
  localparam logic [2:0] ADDR_VIB      = 3'b110;

  localparam int MIN_TEMPO = 4;

  // Enable register word: gate bit plus the two always-on channel enables.
  function automatic logic [4:0] enable_word(input logic gate);
    return {2'b00, gate, 2'b11};
  endfunction

endpackage

// File: rtl/tempo_divider.sv
// Step timer: counts a loaded value down to zero and raises a zero flag.
module tempo_divider
  import seq_controller_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // The zero flag trails the count by one cycle, so a load of N holds the
  // sequencer in WAIT for N+2 cycles and a full step lasts eff_tempo cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_value;
      zero  <= 1'b0;
    end else begin
      if (count != '0) count <= count - 1'b1;
      zero <= (count == '0);
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Pattern sequencer: plays a programmable step table as period/enable register
// writes to a signal generator, sharing the bus with host write requests.
module seq_controller
  import seq_controller_pkg::*;
#(
  parameter int  STEPS   = 8,
  parameter int  TEMPO_W = 16,
  localparam int IDX_W   = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [IDX_W-1:0]   length,
  input  logic               prog_we,
  input  logic [IDX_W-1:0]   prog_idx,
  input  logic [5:0]         prog_entry,
  input  logic               host_valid,
  input  logic [2:0]         host_addr,
  input  logic [4:0]         host_data,
  output logic               host_ready,
  output logic               write_strobe,
  output logic [2:0]         address,
  output logic [4:0]         data,
  output logic [IDX_W-1:0]   step_idx,
  output logic               busy
);

  state_t             state;
  logic [5:0]         pattern [STEPS];
  logic [5:0]         latched;
  logic               zero;
  logic               host_accept;
  logic               load;
  logic [TEMPO_W-1:0] eff_tempo;
  logic [IDX_W-1:0]   next_idx;

  assign busy        = (state != S_IDLE);
  assign host_ready  = rst && ((state == S_IDLE) || ((state == S_WAIT) && !zero));
  assign host_accept = host_valid && host_ready;
  assign eff_tempo   = (tempo < TEMPO_W'(MIN_TEMPO)) ? TEMPO_W'(MIN_TEMPO) : tempo;
  assign load        = (state == S_WR_ENABLE) && run;
  // A length shrunk below the current step wraps straight back to step 0.
  assign next_idx    = (step_idx >= length) ? '0 : step_idx + 1'b1;

  tempo_divider #(.W(TEMPO_W)) u_tempo_divider (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (eff_tempo - TEMPO_W'(MIN_TEMPO)),
    .zero       (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
    end else if (prog_we) begin
      pattern[prog_idx] <= prog_entry;
    end
  end

  // Host writes are only accepted in states whose next edge issues no
  // sequencer write, so the two sources never collide on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      write_strobe <= 1'b0;
      address      <= '0;
      data         <= '0;
      step_idx     <= '0;
      latched      <= '0;
    end else begin
      write_strobe <= host_accept;
      if (host_accept) begin
        address <= host_addr;
        data    <= host_data;
      end
      case (state)
        S_IDLE: begin
          if (run) begin
            state   <= S_WR_PERIOD;
            latched <= pattern[step_idx];
          end
        end
        S_WR_PERIOD: begin
          write_strobe <= 1'b1;
          address      <= ADDR_PERIOD_A;
          data         <= latched[4:0];
          state        <= S_WR_ENABLE;
        end
        S_WR_ENABLE: begin
          write_strobe <= 1'b1;
          address      <= ADDR_ENABLE;
          data         <= enable_word(latched[5]);
          step_idx     <= next_idx;
          state        <= run ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (!run) begin
            state <= S_IDLE;
          end else if (zero) begin
            state   <= S_WR_PERIOD;
            latched <= pattern[step_idx];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: directed vector table, multi-cycle
// corner sequences and randomized laps against an arithmetic playback model.
module tb_seq_controller;
  import seq_controller_pkg::*;

  localparam int STEPS   = 8;
  localparam int TEMPO_W = 16;
  localparam int IDX_W   = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               run = 1'b0;
  logic [TEMPO_W-1:0] tempo = '0;
  logic [IDX_W-1:0]   length = '0;
  logic               prog_we = 1'b0;
  logic [IDX_W-1:0]   prog_idx = '0;
  logic [5:0]         prog_entry = '0;
  logic               host_valid = 1'b0;
  logic [2:0]         host_addr = '0;
  logic [4:0]         host_data = '0;
  logic               host_ready;
  logic               write_strobe;
  logic [2:0]         address;
  logic [4:0]         data;
  logic [IDX_W-1:0]   step_idx;
  logic               busy;

  typedef struct {int cyc; logic [2:0] wa; logic [4:0] wd;} wr_t;
  typedef struct {int t_in; logic [5:0] entry; logic [4:0] exp_period; logic [4:0] exp_enable; int exp_gap;} vec_t;

  wr_t        wq[$];
  vec_t       vecs[7];
  logic [5:0] model_tab[STEPS];
  int         cycle = 0;
  int         checks = 0;
  int         failures = 0;

  seq_controller #(.STEPS(STEPS), .TEMPO_W(TEMPO_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .tempo        (tempo),
    .length       (length),
    .prog_we      (prog_we),
    .prog_idx     (prog_idx),
    .prog_entry   (prog_entry),
    .host_valid   (host_valid),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .host_ready   (host_ready),
    .write_strobe (write_strobe),
    .address      (address),
    .data         (data),
    .step_idx     (step_idx),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;
  always @(negedge clk) if (write_strobe) wq.push_back('{cyc: cycle, wa: address, wd: data});

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, "_strobe"}, int'(write_strobe), 0);
    check_output({tag, "_address"}, int'(address), 0);
    check_output({tag, "_data"}, int'(data), 0);
    check_output({tag, "_step_idx"}, int'(step_idx), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_host_ready"}, int'(host_ready), 0);
  endtask

  // Compares the live bus as {strobe, address, data} against a strobed word.
  task automatic check_bus(input string name, input logic [7:0] exp_word);
    check_output(name, int'({write_strobe, address, data}), int'({1'b1, exp_word}));
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; prog_we = 1'b0; host_valid = 1'b0;
    tempo = '0; length = '0; prog_idx = '0; prog_entry = '0; host_addr = '0; host_data = '0;
    step(2);
    check_zero("reset");
    rst = 1'b1;
    step(1);
    wq.delete();
  endtask

  task automatic prog(input int idx, input logic [5:0] entry);
    prog_we = 1'b1; prog_idx = IDX_W'(idx); prog_entry = entry;
    step(1);
    prog_we = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    int t = 0;
    while (wq.size() < n && t < 400) begin
      step(1);
      t++;
    end
    check_output(name, (wq.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_strobe(input logic [2:0] addr, input string name);
    int t = 0;
    while (!(write_strobe && address == addr) && t < 200) begin
      step(1);
      t++;
    end
    check_output(name, int'(write_strobe && address == addr), 1);
  endtask

  task automatic stop_run(input string name);
    int t = 0;
    run = 1'b0;
    while (busy && t < 50) begin
      step(1);
      t++;
    end
    check_output(name, int'(busy), 0);
  endtask

  function automatic int model_word(input int n, input int len);
    logic [5:0] e;
    e = model_tab[(n / 2) % (len + 1)];
    if (n % 2 == 0) return int'({3'b000, e[4:0]});
    return int'({3'b101, 2'b00, e[5], 2'b11});
  endfunction

  function automatic int model_time(input int n, input int tempo_v);
    int eff;
    eff = (tempo_v < MIN_TEMPO) ? MIN_TEMPO : tempo_v;
    return (n / 2) * eff + (n % 2);
  endfunction

  task automatic apply_stimulus(input vec_t v, input int i);
    do_reset();
    prog(0, v.entry);
    length = '0;
    tempo  = TEMPO_W'(v.t_in);
    run    = 1'b1;
    wait_writes(3, $sformatf("vec%0d_writes", i));
    if (wq.size() >= 3) begin
      check_output($sformatf("vec%0d_period", i), int'({wq[0].wa, wq[0].wd}), int'({ADDR_PERIOD_A, v.exp_period}));
      check_output($sformatf("vec%0d_enable", i), int'({wq[1].wa, wq[1].wd}), int'({ADDR_ENABLE, v.exp_enable}));
      check_output($sformatf("vec%0d_pair_gap", i), wq[1].cyc - wq[0].cyc, 1);
      check_output($sformatf("vec%0d_next_period", i), int'({wq[2].wa, wq[2].wd}), int'({ADDR_PERIOD_A, v.exp_period}));
      check_output($sformatf("vec%0d_step_gap", i), wq[2].cyc - wq[0].cyc, v.exp_gap);
    end
    stop_run($sformatf("vec%0d_stop", i));
  endtask

  initial begin
    logic [7:0] exp31[6];
    int len_v, tempo_v, nw, t, hostcnt;

    vecs[0] = '{10, 6'h25, 5'h05, 5'h07, 10};
    vecs[1] = '{2,  6'h0A, 5'h0A, 5'h03, 4};
    vecs[2] = '{0,  6'h3F, 5'h1F, 5'h07, 4};
    vecs[3] = '{4,  6'h20, 5'h00, 5'h07, 4};
    vecs[4] = '{5,  6'h1F, 5'h1F, 5'h03, 5};
    vecs[5] = '{3,  6'h11, 5'h11, 5'h03, 4};
    vecs[6] = '{17, 6'h2A, 5'h0A, 5'h07, 17};
    exp31 = '{8'h05, 8'hA7, 8'h0A, 8'hA3, 8'h05, 8'hA7};

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);

    // Two-step pattern at tempo 10.
    do_reset();
    prog(0, 6'h25); prog(1, 6'h0A);
    length = 3'd1; tempo = 16'd10; run = 1'b1;
    wait_writes(6, "basic_writes");
    if (wq.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check_output($sformatf("basic_w%0d", k), int'({wq[k].wa, wq[k].wd}), int'(exp31[k]));
        check_output($sformatf("basic_t%0d", k), wq[k].cyc - wq[0].cyc, (k / 2) * 10 + (k % 2));
      end
    end
    stop_run("basic_stop");

    // Host request held across a step boundary.
    do_reset();
    prog(0, 6'h25);
    length = '0; tempo = 16'd10; run = 1'b1;
    wait_strobe(ADDR_PERIOD_A, "host_first_period");
    step(9);
    host_addr = 3'b010; host_data = 5'h0F; host_valid = 1'b1;
    check_output("host_ready_wr_period", int'(host_ready), 0);
    step(1);
    check_bus("host_seq_period", 8'h05);
    check_output("host_ready_wr_enable", int'(host_ready), 0);
    step(1);
    check_bus("host_seq_enable", 8'hA7);
    check_output("host_ready_wait", int'(host_ready), 1);
    step(1);
    check_bus("host_write", {3'b010, 5'h0F});
    host_valid = 1'b0;
    wq.delete();
    step(20);
    hostcnt = 0;
    foreach (wq[k]) if (wq[k].wa == 3'b010) hostcnt++;
    check_output("host_write_once", hostcnt, 0);
    stop_run("host_stop");

    // run dropped during WR_PERIOD, then resumed.
    do_reset();
    prog(0, 6'h25); prog(1, 6'h0A); prog(2, 6'h33);
    length = 3'd2; tempo = 16'd10; run = 1'b1;
    wait_strobe(ADDR_PERIOD_A, "pause_first_period");
    step(9);
    check_output("pause_idx_before", int'(step_idx), 1);
    run = 1'b0;
    step(1);
    check_bus("pause_period", 8'h0A);
    step(1);
    check_bus("pause_enable", 8'hA3);
    check_output("pause_busy", int'(busy), 0);
    check_output("pause_idx", int'(step_idx), 2);
    wq.delete();
    step(5);
    check_output("pause_quiet", wq.size(), 0);
    check_output("pause_idx_hold", int'(step_idx), 2);
    run = 1'b1;
    wait_strobe(ADDR_PERIOD_A, "resume_seen");
    check_output("resume_period", int'(data), 5'h13);
    step(1);
    check_bus("resume_enable", 8'hA7);
    check_output("resume_idx_wrap", int'(step_idx), 0);
    stop_run("resume_stop");

    // Reset pulse during WAIT at step 3.
    do_reset();
    prog(0, 6'h21); prog(1, 6'h0A); prog(2, 6'h0B); prog(3, 6'h2C);
    length = 3'd3; tempo = 16'd8; run = 1'b1;
    t = 0;
    while (!(write_strobe && address == ADDR_ENABLE && step_idx == 3'd3) && t < 300) begin
      step(1);
      t++;
    end
    check_output("midrst_reach_step3", int'(write_strobe && address == ADDR_ENABLE && step_idx == 3'd3), 1);
    step(2);
    check_output("midrst_in_wait", int'(busy), 1);
    rst = 1'b0; run = 1'b0;
    #1;
    check_zero("midrst");
    step(2);
    rst = 1'b1;
    wq.delete();
    step(6);
    check_output("midrst_no_strobe", wq.size(), 0);
    run = 1'b1;
    wait_writes(2, "midrst_writes");
    if (wq.size() >= 2) begin
      check_output("midrst_period", int'({wq[0].wa, wq[0].wd}), 8'h00);
      check_output("midrst_enable", int'({wq[1].wa, wq[1].wd}), 8'hA3);
    end
    stop_run("midrst_stop");

    // Table rewrite on the same edge the step is latched.
    do_reset();
    prog(0, 6'h25);
    length = '0; tempo = 16'd10; run = 1'b1;
    wait_strobe(ADDR_PERIOD_A, "latch_first_period");
    step(8);
    prog_we = 1'b1; prog_idx = '0; prog_entry = 6'h0E;
    step(1);
    prog_we = 1'b0;
    step(1);
    check_bus("latch_old_period", 8'h05);
    step(1);
    check_bus("latch_old_enable", 8'hA7);
    step(9);
    check_bus("latch_new_period", 8'h0E);
    step(1);
    check_bus("latch_new_enable", 8'hA3);
    stop_run("latch_stop");

    // Randomized tables, lengths and tempos against the playback model.
    for (int r = 0; r < 5; r++) begin
      len_v   = int'($urandom_range(STEPS - 1, 0));
      tempo_v = int'($urandom_range(12, 0));
      do_reset();
      for (int i = 0; i < STEPS; i++) begin
        model_tab[i] = 6'($urandom);
        prog(i, model_tab[i]);
      end
      length = IDX_W'(len_v); tempo = TEMPO_W'(tempo_v); run = 1'b1;
      nw = 2 * (len_v + 2);
      wait_writes(nw, $sformatf("rand%0d_writes", r));
      if (wq.size() >= nw) begin
        for (int k = 0; k < nw; k++) begin
          check_output($sformatf("rand%0d_w%0d", r, k), int'({wq[k].wa, wq[k].wd}), model_word(k, len_v));
          check_output($sformatf("rand%0d_t%0d", r, k), wq[k].cyc - wq[0].cyc, model_time(k, tempo_v));
        end
      end
      stop_run($sformatf("rand%0d_stop", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
